busca_instrucao: RTL and testbench



---
 rtl/pem_pkg.sv | 27 ++
 rtl/mem_programa.sv | 41 ++++
 rtl/busca_instrucao.sv | 116 +++++++++++
 tb/tb_busca_instrucao.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pem_pkg.sv
// Shared definitions for the instruction-fetch stage and the ULA.
// Holds the address/data widths, the opcode constants, the 2-bit fetch
// state encoding and a small opcode-classification helper.
package pem_pkg;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDA  = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_JMP  = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_EXEC   = 2'd2,
        ST_HALTED = 2'd3
    } state_t;

    // JMP and HALT are consumed by the fetch unit; everything else goes to the ULA.
    function automatic logic is_issued(input logic [3:0] op);
        return (op != OP_JMP) && (op != OP_HALT);
    endfunction

endpackage

// File: rtl/mem_programa.sv
// 16x8 program memory: one synchronous write port, one synchronous read port.
// Ports:
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset (clears only the read register)
//   wr_en    in   write strobe
//   wr_addr  in   write address
//   wr_data  in   write data
//   rd_en    in   read strobe; rd_data updates only when high
//   rd_addr  in   read address
//   rd_data  out  registered read data (the fetched instruction)
module mem_programa
    import pem_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    // Storage is never reset; contents survive a Reset of the fetch stage.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/busca_instrucao.sv
// Instruction fetch/sequencer stage feeding the ULA.
// Steps a 4-bit program counter through mem_programa, consumes JMP/HALT
// locally and issues every other instruction on barramentoDados with a
// one-cycle active-low RegEnable strobe (one instruction per 2 cycles).
// Ports:
//   Clock            in   system clock, rising edge
//   Reset            in   synchronous active-high reset
//   step, step_mode  in   single-step control (only with BUSCA_STEP_EN defined)
//   start            in   start from pc=0 (honoured in IDLE/HALTED)
//   prog_we          in   program write strobe (honoured in IDLE/HALTED)
//   prog_addr        in   program write address
//   prog_data        in   program write data
//   barramentoDados  out  last issued instruction
//   RegEnable        out  active-low issue strobe, one cycle per issue
//   pc               out  program counter
//   running          out  high in FETCH/EXEC
//   halted           out  high in HALTED
// Optional feature macro: BUSCA_STEP_EN (adds step/step_mode; with
// step_mode=1 FETCH waits for step=1).
module busca_instrucao
    import pem_pkg::*;
(
    input  logic              Clock,
    input  logic              Reset,
`ifdef BUSCA_STEP_EN
    input  logic              step,
    input  logic              step_mode,
`endif
    input  logic              start,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    output logic [DATA_W-1:0] barramentoDados,
    output logic              RegEnable,
    output logic [ADDR_W-1:0] pc,
    output logic              running,
    output logic              halted
);

    state_t            state;
    logic [DATA_W-1:0] instr_q;
    logic              fetch_go;
    logic              mem_wr;
    logic              mem_rd;
    logic              loadable;

`ifdef BUSCA_STEP_EN
    assign fetch_go = ~step_mode | step;
`else
    assign fetch_go = 1'b1;
`endif

    assign loadable = (state == ST_IDLE) || (state == ST_HALTED);
    // Reset also blocks a coincident program write.
    assign mem_wr   = prog_we & loadable & ~Reset;
    assign mem_rd   = (state == ST_FETCH) & fetch_go;

    mem_programa u_mem (
        .clk     (Clock),
        .rst     (Reset),
        .wr_en   (mem_wr),
        .wr_addr (prog_addr),
        .wr_data (prog_data),
        .rd_en   (mem_rd),
        .rd_addr (pc),
        .rd_data (instr_q)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state           <= ST_IDLE;
            pc              <= '0;
            barramentoDados <= '0;
            RegEnable       <= 1'b1;
            running         <= 1'b0;
            halted          <= 1'b0;
        end else begin
            // Strobe defaults high so an issue pulse lasts exactly one cycle.
            RegEnable <= 1'b1;
            case (state)
                ST_IDLE, ST_HALTED: begin
                    if (start) begin
                        pc      <= '0;
                        state   <= ST_FETCH;
                        running <= 1'b1;
                        halted  <= 1'b0;
                    end
                end
                ST_FETCH: begin
                    if (fetch_go) begin
                        state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (instr_q[7:4] == OP_HALT) begin
                        state   <= ST_HALTED;
                        running <= 1'b0;
                        halted  <= 1'b1;
                    end else if (instr_q[7:4] == OP_JMP) begin
                        pc    <= instr_q[3:0];
                        state <= ST_FETCH;
                    end else if (is_issued(instr_q[7:4])) begin
                        barramentoDados <= instr_q;
                        RegEnable       <= 1'b0;
                        pc              <= pc + 4'd1;
                        state           <= ST_FETCH;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_busca_instrucao.sv
module tb_busca_instrucao;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       start = 1'b0;
    logic       prog_we = 1'b0;
    logic [3:0] prog_addr = 4'd0;
    logic [7:0] prog_data = 8'd0;
`ifdef BUSCA_STEP_EN
    logic       step = 1'b0;
    logic       step_mode = 1'b0;
`endif
    logic [7:0] barramentoDados;
    logic       RegEnable;
    logic [3:0] pc;
    logic       running;
    logic       halted;

    always #5 Clock = ~Clock;

    busca_instrucao dut (
        .Clock           (Clock),
        .Reset           (Reset),
`ifdef BUSCA_STEP_EN
        .step            (step),
        .step_mode       (step_mode),
`endif
        .start           (start),
        .prog_we         (prog_we),
        .prog_addr       (prog_addr),
        .prog_data       (prog_data),
        .barramentoDados (barramentoDados),
        .RegEnable       (RegEnable),
        .pc              (pc),
        .running         (running),
        .halted          (halted)
    );

    int checks = 0;
    int errors = 0;

    // Bench copy of the program and the expected per-cycle trace.
    logic [7:0] model_mem [0:15];
    logic [7:0] last_bus;
    logic       exp_re   [0:63];
    logic [7:0] exp_bus  [0:63];
    logic [3:0] exp_pc   [0:63];
    logic       exp_run  [0:63];
    logic       exp_halt [0:63];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    // Program-level model: each instruction slot takes two cycles; sample n is
    // taken after the n-th edge counting the start edge as 0.
    task automatic build_model(input int ncyc);
        int         pcm;
        logic       hlt;
        logic [7:0] bus;
        logic [7:0] ins;
        logic       re;
        pcm = 0;
        hlt = 1'b0;
        bus = last_bus;
        exp_re[0] = 1'b1; exp_bus[0] = bus; exp_pc[0] = 4'd0;
        exp_run[0] = 1'b1; exp_halt[0] = 1'b0;
        for (int n = 1; n <= ncyc; n++) begin
            re = 1'b1;
            if (!hlt && (n % 2 == 0)) begin
                ins = model_mem[pcm];
                if (ins[7:4] == 4'hF) begin
                    hlt = 1'b1;
                end else if (ins[7:4] == 4'hE) begin
                    pcm = int'(ins[3:0]);
                end else begin
                    bus = ins;
                    re  = 1'b0;
                    pcm = (pcm + 1) % 16;
                end
            end
            exp_re[n] = re; exp_bus[n] = bus; exp_pc[n] = 4'(pcm);
            exp_run[n] = !hlt; exp_halt[n] = hlt;
        end
    endtask

    task automatic write_mem(input logic [3:0] a, input logic [7:0] d);
        prog_we = 1'b1; prog_addr = a; prog_data = d;
        @(negedge Clock);
        prog_we = 1'b0;
        model_mem[a] = d;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;
        last_bus = 8'h00;
    endtask

    task automatic run_prog(input string name, input int ncyc, input int we_n,
                            input logic [3:0] we_a, input logic [7:0] we_d, output int strobes);
        build_model(ncyc);
        strobes = 0;
        start = 1'b1;
        @(negedge Clock);
        start = 1'b0;
        for (int n = 0; n <= ncyc; n++) begin
            if (n > 0) @(negedge Clock);
            check($sformatf("%s_re_%0d", name, n), 32'(RegEnable), 32'(exp_re[n]));
            check($sformatf("%s_bus_%0d", name, n), 32'(barramentoDados), 32'(exp_bus[n]));
            check($sformatf("%s_pc_%0d", name, n), 32'(pc), 32'(exp_pc[n]));
            check($sformatf("%s_run_%0d", name, n), 32'(running), 32'(exp_run[n]));
            check($sformatf("%s_halt_%0d", name, n), 32'(halted), 32'(exp_halt[n]));
            if (RegEnable === 1'b0) strobes++;
            if (n == we_n) begin
                prog_we = 1'b1; prog_addr = we_a; prog_data = we_d;
            end else begin
                prog_we = 1'b0;
            end
        end
        prog_we = 1'b0;
        last_bus = exp_bus[ncyc];
    endtask

    initial begin
        int s;
        last_bus = 8'h00;
        for (int i = 0; i < 16; i++) model_mem[i] = 8'hF0;
        @(negedge Clock);
        @(negedge Clock);
        Reset = 1'b0;
        check("rst_re", 32'(RegEnable), 32'd1);
        check("rst_bus", 32'(barramentoDados), 32'h00);
        check("rst_pc", 32'(pc), 32'd0);
        check("rst_run", 32'(running), 32'd0);
        check("rst_halt", 32'(halted), 32'd0);

        // Basic program with HALT
        write_mem(4'd0, 8'h15);
        write_mem(4'd1, 8'h23);
        write_mem(4'd2, 8'hF0);
        run_prog("t1", 10, -1, 4'd0, 8'd0, s);
        check("t1_strobes", 32'(s), 32'd2);
        check("t1_pc_end", 32'(pc), 32'd2);

        // Wrap-around of the program counter
        do_reset();
        for (int i = 0; i < 16; i++) write_mem(4'(i), 8'h01);
        run_prog("t2", 32, -1, 4'd0, 8'd0, s);
        check("t2_strobes", 32'(s), 32'd16);
        check("t2_running", 32'(running), 32'd1);

        // Jump
        do_reset();
        write_mem(4'd0, 8'hE5);
        write_mem(4'd5, 8'h17);
        write_mem(4'd6, 8'hFF);
        run_prog("t3", 10, -1, 4'd0, 8'd0, s);
        check("t3_strobes", 32'(s), 32'd1);
        check("t3_bus", 32'(barramentoDados), 32'h17);
        check("t3_pc_end", 32'(pc), 32'd6);

        // Reset in the EXEC cycle of an issuing instruction
        do_reset();
        write_mem(4'd0, 8'h15);
        start = 1'b1;
        @(negedge Clock);
        start = 1'b0;
        @(negedge Clock);
        check("t4_exec_run", 32'(running), 32'd1);
        Reset = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;
        check("t4_re", 32'(RegEnable), 32'd1);
        check("t4_pc", 32'(pc), 32'd0);
        check("t4_bus", 32'(barramentoDados), 32'h00);
        check("t4_run", 32'(running), 32'd0);
        check("t4_halt", 32'(halted), 32'd0);
        @(negedge Clock);
        check("t4_re_next", 32'(RegEnable), 32'd1);
        last_bus = 8'h00;

        // Writes ignored while running, honoured when halted
        do_reset();
        write_mem(4'd0, 8'h11);
        write_mem(4'd1, 8'h22);
        write_mem(4'd2, 8'hF0);
        run_prog("t5a", 8, 1, 4'd1, 8'h99, s);
        check("t5a_strobes", 32'(s), 32'd2);
        write_mem(4'd1, 8'h2A);
        run_prog("t5b", 8, -1, 4'd0, 8'd0, s);
        check("t5b_strobes", 32'(s), 32'd2);
        check("t5b_bus", 32'(barramentoDados), 32'h2A);

        // Random programs against the model
        for (int k = 0; k < 4; k++) begin
            do_reset();
            for (int i = 0; i < 16; i++) write_mem(4'(i), 8'($urandom_range(0, 255)));
            run_prog($sformatf("rnd%0d", k), 40, -1, 4'd0, 8'd0, s);
        end

`ifdef BUSCA_STEP_EN
        // Single-step mode
        do_reset();
        write_mem(4'd0, 8'h15);
        write_mem(4'd1, 8'hF0);
        step_mode = 1'b1;
        step = 1'b0;
        start = 1'b1;
        @(negedge Clock);
        start = 1'b0;
        s = 0;
        for (int n = 0; n < 10; n++) begin
            if (RegEnable === 1'b0) s++;
            @(negedge Clock);
        end
        check("t6_stall_strobes", 32'(s), 32'd0);
        check("t6_stall_pc", 32'(pc), 32'd0);
        step = 1'b1;
        @(negedge Clock);
        step = 1'b0;
        check("t6_re_1", 32'(RegEnable), 32'd1);
        @(negedge Clock);
        check("t6_re_2", 32'(RegEnable), 32'd0);
        check("t6_bus", 32'(barramentoDados), 32'h15);
        s = 0;
        for (int n = 0; n < 6; n++) begin
            @(negedge Clock);
            if (RegEnable === 1'b0) s++;
        end
        check("t6_extra_strobes", 32'(s), 32'd0);
        step_mode = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
